// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared state type, defaults and width helper for the deserializer
package deser_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic {
        RECEIVING = 1'b0,
        BLOCKED   = 1'b1
    } deser_state_t;

    // Never returns 0, so counters and pointers stay at least one bit wide.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/deser_word_fifo.sv
// rtl/deser_word_fifo.sv - DEPTH x WIDTH word queue with separate fill counter
module deser_word_fifo
    import deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int FILL_W = $clog2(DEPTH + 1)
) (
    input  logic              clock_100KHz,
    input  logic              reset,
    input  logic              push,
    input  logic [WIDTH-1:0]  push_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  head,
    output logic [FILL_W-1:0] fill,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = cnt_width(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (fill == FILL_MAX);
    assign empty   = (fill == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock_100KHz) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Explicit wrap keeps non-power-of-two DEPTH values safe too.
    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                fill <= fill + FILL_W'(1);
            end else if (do_pop && !do_push) begin
                fill <= fill - FILL_W'(1);
            end
        end
    end

endmodule

// File: rtl/deserializador_param.sv
// rtl/deserializador_param.sv - serial-to-word deserializer with buffered output words
module deserializador_param
    import deser_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter bit MSB_FIRST = 1'b0,
    localparam int FILL_W   = $clog2(DEPTH + 1)
) (
    input  logic              clock_100KHz,
    input  logic              reset,
    input  logic              data_in,
    input  logic              write_in,
    output logic              data_ready,
    output logic [WIDTH-1:0]  data_out,
    input  logic              ack_in,
    output logic              status_out,
    output logic              overrun_out,
    output logic [FILL_W-1:0] fill_out
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST      = CNT_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0] FILL_PRE_FULL = FILL_W'(DEPTH - 1);

    deser_state_t     state;
    logic [CNT_W-1:0] bit_cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;

    assign accept     = write_in && status_out;
    assign push       = accept && (bit_cnt == CNT_LAST);
    assign pop        = ack_in && data_ready;
    assign data_ready = !empty;
    assign data_out   = empty ? '0 : head;
    assign status_out = !full;

    // next_word already contains the incoming bit, so the completing edge pushes it directly.
    always_comb begin
        next_word = shift_reg;
        if (MSB_FIRST) begin
            next_word = {shift_reg[WIDTH-2:0], data_in};
        end else begin
            next_word[bit_cnt] = data_in;
        end
    end

    always_ff @(posedge clock_100KHz or negedge reset) begin
        if (!reset) begin
            state       <= RECEIVING;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            overrun_out <= 1'b0;
        end else begin
            if (accept) begin
                if (push) begin
                    bit_cnt   <= '0;
                    shift_reg <= '0;
                end else begin
                    bit_cnt   <= bit_cnt + CNT_W'(1);
                    shift_reg <= next_word;
                end
            end
            if (state == BLOCKED && write_in) begin
                overrun_out <= 1'b1;
            end
            case (state)
                RECEIVING: if (push && !pop && fill_out == FILL_PRE_FULL) state <= BLOCKED;
                BLOCKED:   if (pop) state <= RECEIVING;
                default:   state <= RECEIVING;
            endcase
        end
    end

    deser_word_fifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock_100KHz(clock_100KHz),
        .reset       (reset),
        .push        (push),
        .push_data   (next_word),
        .pop         (pop),
        .head        (head),
        .fill        (fill_out),
        .full        (full),
        .empty       (empty)
    );

endmodule

// File: tb/tb_deserializador_param.sv
// tb/tb_deserializador_param.sv - bench running LSB-first and MSB-first instances side by side
module tb_deserializador_param;

    logic       clock_100KHz = 1'b0;
    logic       reset;
    logic       data_in;
    logic       write_in;
    logic       ack_in;
    logic       ready_a, ready_b;
    logic       status_a, status_b;
    logic       overrun_a, overrun_b;
    logic [7:0] out_a, out_b;
    logic [2:0] fill_a, fill_b;

    typedef struct {
        logic [7:0] stream;
        logic [7:0] exp_lsb;
        logic [7:0] exp_msb;
    } vec_t;

    typedef struct {
        logic [7:0] lsb;
        logic [7:0] msb;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clock_100KHz = ~clock_100KHz;

    deserializador_param #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clock_100KHz(clock_100KHz), .reset(reset), .data_in(data_in), .write_in(write_in),
        .data_ready(ready_a), .data_out(out_a), .ack_in(ack_in), .status_out(status_a),
        .overrun_out(overrun_a), .fill_out(fill_a)
    );

    deserializador_param #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) dut_msb (
        .clock_100KHz(clock_100KHz), .reset(reset), .data_in(data_in), .write_in(write_in),
        .data_ready(ready_b), .data_out(out_b), .ack_in(ack_in), .status_out(status_b),
        .overrun_out(overrun_b), .fill_out(fill_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic rdy, input logic [2:0] fill,
                               input logic status);
        check({name, "_ready_lsb"},  32'(ready_a),  32'(rdy));
        check({name, "_ready_msb"},  32'(ready_b),  32'(rdy));
        check({name, "_fill_lsb"},   32'(fill_a),   32'(fill));
        check({name, "_fill_msb"},   32'(fill_b),   32'(fill));
        check({name, "_status_lsb"}, 32'(status_a), 32'(status));
        check({name, "_status_msb"}, 32'(status_b), 32'(status));
    endtask

    task automatic send_bit(input logic b);
        write_in = 1'b1;
        data_in  = b;
        @(posedge clock_100KHz); #1;
        write_in = 1'b0;
        data_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock_100KHz); #1;
        end
    endtask

    task automatic send_word(input int idx);
        for (int k = 7; k >= 0; k--) send_bit(vecs[idx].stream[k]);
        sb.push_back('{vecs[idx].exp_lsb, vecs[idx].exp_msb});
    endtask

    // Compares the head of both instances against the scoreboard, then acks it.
    task automatic pop_check(input string name);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard_empty actual=%0h required=none", name, out_a);
        end else begin
            e = sb.pop_front();
            check({name, "_head_lsb"}, 32'(out_a), 32'(e.lsb));
            check({name, "_head_msb"}, 32'(out_b), 32'(e.msb));
        end
        ack_in = 1'b1;
        @(posedge clock_100KHz); #1;
        ack_in = 1'b0;
    endtask

    task automatic check_overrun(input string name, input logic exp);
        check({name, "_lsb"}, 32'(overrun_a), 32'(exp));
        check({name, "_msb"}, 32'(overrun_b), 32'(exp));
    endtask

    initial begin
        exp_t e;
        reset    = 1'b0;
        data_in  = 1'b0;
        write_in = 1'b0;
        ack_in   = 1'b0;
        // stream is written in arrival order: stream[7] is the first bit sent.
        vecs[0] = '{8'b10110010, 8'h4D, 8'hB2};
        vecs[1] = '{8'b10001000, 8'h11, 8'h88};
        vecs[2] = '{8'b01000100, 8'h22, 8'h44};
        vecs[3] = '{8'b11001100, 8'h33, 8'hCC};
        vecs[4] = '{8'b00100010, 8'h44, 8'h22};
        vecs[5] = '{8'b00000001, 8'h80, 8'h01};

        idle(2);
        check_state("reset", 1'b0, 3'd0, 1'b1);
        check("reset_out_lsb", 32'(out_a), 32'h0);
        check("reset_out_msb", 32'(out_b), 32'h0);
        check_overrun("reset_overrun", 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            for (int k = 7; k >= 1; k--) send_bit(vecs[i].stream[k]);
            check_state($sformatf("vec%0d_partial", i), 1'b0, 3'd0, 1'b1);
            send_bit(vecs[i].stream[0]);
            sb.push_back('{vecs[i].exp_lsb, vecs[i].exp_msb});
            check_state($sformatf("vec%0d_done", i), 1'b1, 3'd1, 1'b1);
            pop_check($sformatf("vec%0d", i));
            check_state($sformatf("vec%0d_popped", i), 1'b0, 3'd0, 1'b1);
            check($sformatf("vec%0d_out_zero_lsb", i), 32'(out_a), 32'h0);
            check($sformatf("vec%0d_out_zero_msb", i), 32'(out_b), 32'h0);
        end

        for (int i = 1; i <= 4; i++) send_word(i);
        check_state("full", 1'b1, 3'd4, 1'b0);
        check_overrun("full_no_overrun", 1'b0);
        send_bit(1'b1);
        check_overrun("overrun_set", 1'b1);
        idle(3);
        check_overrun("overrun_sticky", 1'b1);
        check_state("full_after_drop", 1'b1, 3'd4, 1'b0);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("drain%0d", i));
        check_state("drained", 1'b0, 3'd0, 1'b1);
        send_word(0);
        pop_check("after_drop_word");

        send_word(1);
        send_word(2);
        for (int k = 7; k >= 1; k--) send_bit(vecs[3].stream[k]);
        e = sb.pop_front();
        check("simul_head_lsb", 32'(out_a), 32'(e.lsb));
        check("simul_head_msb", 32'(out_b), 32'(e.msb));
        write_in = 1'b1;
        data_in  = vecs[3].stream[0];
        ack_in   = 1'b1;
        @(posedge clock_100KHz); #1;
        write_in = 1'b0;
        ack_in   = 1'b0;
        sb.push_back('{vecs[3].exp_lsb, vecs[3].exp_msb});
        check_state("simul", 1'b1, 3'd2, 1'b1);
        pop_check("simul_second");
        pop_check("simul_tail");
        check_state("simul_drained", 1'b0, 3'd0, 1'b1);

        for (int k = 7; k >= 3; k--) send_bit(vecs[0].stream[k]);
        idle(20);
        check_state("pause", 1'b0, 3'd0, 1'b1);
        for (int k = 2; k >= 0; k--) send_bit(vecs[0].stream[k]);
        sb.push_back('{vecs[0].exp_lsb, vecs[0].exp_msb});
        idle(3);
        check_state("pause_done", 1'b1, 3'd1, 1'b1);
        pop_check("pause_word");
        check_state("pause_drained", 1'b0, 3'd0, 1'b1);

        send_word(1);
        send_word(2);
        for (int k = 7; k >= 5; k--) send_bit(vecs[3].stream[k]);
        check_state("pre_reset", 1'b1, 3'd2, 1'b1);
        check_overrun("pre_reset_overrun", 1'b1);
        reset = 1'b0;
        #2;
        check_state("async_reset", 1'b0, 3'd0, 1'b1);
        check_overrun("async_reset_overrun", 1'b0);
        check("async_reset_out_lsb", 32'(out_a), 32'h0);
        check("async_reset_out_msb", 32'(out_b), 32'h0);
        @(posedge clock_100KHz); #1;
        reset = 1'b1;
        sb.delete();
        send_word(0);
        check_state("fresh", 1'b1, 3'd1, 1'b1);
        pop_check("fresh_word");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/deserializador_param.md
Name: deserializador_param

Overview:
- Parametrised successor to the 8-bit deserializer.
- Assembles serial bits from data_in into WIDTH-bit words and queues completed words in a DEPTH-entry output buffer.
- Keeps receiving while earlier words wait for ack_in, and supports LSB-first or MSB-first bit order.
- Sits between the serial source and the queue/consumer logic, on the same slow clock domain.

Parameters:
- WIDTH, 8: word width in bits (2..32).
- DEPTH, 4: number of completed words buffered (power of two, 1..16).
- MSB_FIRST, 0: 0 = first received bit goes to data_out[0]; 1 = first received bit goes to data_out[WIDTH-1].

Ports:
- clock_100KHz  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- data_in  input  1  serial data bit.
- write_in  input  1  data_in is valid this cycle.
- data_ready  output  1  buffer holds at least one complete word.
- data_out  output  WIDTH  oldest complete word.
- ack_in  input  1  consumer takes data_out this cycle.
- status_out  output  1  block can accept serial bits.
- overrun_out  output  1  sticky: a bit was offered while status_out was 0.
- fill_out  output  $clog2(DEPTH+1)  number of buffered words.

Behaviour:
- Reset (reset low, asynchronous): bit counter=0, shift register=0, FIFO empty, fill_out=0, data_ready=0, data_out=0, status_out=1, overrun_out=0, state=RECEIVING.
- Bit acceptance: a bit is taken at the edge only when write_in=1 and status_out=1. Each accepted bit increments the bit counter (0..WIDTH-1).
- Bit placement:
  - MSB_FIRST=0: the k-th accepted bit lands in word bit k.
  - MSB_FIRST=1: the word shifts left and the new bit enters at bit 0, so the first bit ends up at WIDTH-1.
- Word completion: the edge that accepts bit WIDTH-1 pushes the full word (including that bit) into the FIFO and clears the counter and shift register. data_ready is high the cycle after that edge (latency 1 from the last bit).
- Pop: ack_in=1 with data_ready=1 pops the head at the edge. data_out shows the next entry, or 0 when empty, in the following cycle. ack_in with data_ready=0 is ignored.
- Push and pop in the same edge: fill_out unchanged. The popped word is the old head; the pushed word goes to the tail.
- data_out is the combinational head of the FIFO, forced to 0 while data_ready=0.
- status_out = (fill_out < DEPTH). This is combinational from the registered fill, so a pop frees space for the next cycle, not the same one.
- FSM (in the shared package):
  - RECEIVING: fill < DEPTH.
  - BLOCKED: fill == DEPTH.
  - RECEIVING -> BLOCKED on a push that makes fill == DEPTH with no simultaneous pop.
  - BLOCKED -> RECEIVING on any pop.
- In BLOCKED, write_in=1 sets overrun_out=1 (sticky until reset). The bit is dropped and the partial word is left untouched.
- Partial word: a pause in write_in keeps the bit counter and partial word indefinitely. There is no timeout.
- Pointers: read and write pointers wrap modulo DEPTH. fill_out is kept as a separate counter (0..DEPTH); it must never exceed DEPTH or underflow.
- Reset mid-word or with a full FIFO discards everything. Outputs return to reset values immediately, without waiting for a clock edge.

Decomposition:
- Package deser_pkg: state enum (RECEIVING, BLOCKED); a localparam helper for the counter width ($clog2(WIDTH)); default WIDTH/DEPTH constants shared with the queue block.
- Sub-module deser_word_fifo: DEPTH x WIDTH synchronous FIFO with push, pop, head, fill, full and empty; same clock and active-low async reset.
- Top level holds the bit counter, the shift/placement logic, the FSM and overrun_out.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=0, bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles -> data_ready=1 one cycle after the 8th bit, data_out=8'h4D, fill_out=1.
- MSB_FIRST=1, same bit stream -> data_out=8'hB2. Then ack_in=1 for one cycle -> data_ready=0, data_out=0, fill_out=0 next cycle.
- DEPTH=4, send 4 words (8'h11, 8'h22, 8'h33, 8'h44) with no ack -> status_out=0, fill_out=4. Then one more write_in pulse -> overrun_out=1 and stays 1. Then ack four times -> data_out sequence 11, 22, 33, 44, then status_out=1.
- fill_out=2 and the last bit of a word arrives on the same edge as ack_in -> fill_out stays 2, head advances to the second word, the new word is at the tail.
- Send 5 bits, drop write_in for 20 cycles, send 3 more bits -> a single correct word completes and no extra word is pushed.
- Drive reset low mid-word with 2 words buffered -> data_ready=0, fill_out=0, status_out=1, overrun_out=0 asynchronously. The next 8 bits form a fresh word.
